// File: rtl/ee354_project_dirn_queue.sv
// Direction-press queue between the debounced direction buttons and the snake
// length/position module. It buffers up to DEPTH legal presses and rejects
// presses on the same axis as the newest committed or queued direction. Each
// movement tick in Run releases one entry into Cur_Dirn and emits a Step pulse.
//
// Ports:
//   Clk         system clock
//   Reset       synchronous active-low reset
//   SCEN        single-cycle press strobe
//   In_Dirn     encoded press (00 UP, 01 DOWN, 10 LEFT, 11 RIGHT)
//   Speed_Tick  single-cycle movement tick
//   q_I, q_Run  state machine is in Initial / Run
//   Cur_Dirn    committed direction of travel
//   Step        one-cycle pulse: head advances using Cur_Dirn
//   Count       number of queued entries
//   Empty/Full  registered queue status
//   Drop        one-cycle pulse: press rejected
module ee354_project_dirn_queue #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [1:0]  INIT_DIRN = 2'b11
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     SCEN,
  input  logic [1:0]               In_Dirn,
  input  logic                     Speed_Tick,
  input  logic                     q_I,
  input  logic                     q_Run,
  output logic [1:0]               Cur_Dirn,
  output logic                     Step,
  output logic [$clog2(DEPTH):0]   Count,
  output logic                     Empty,
  output logic                     Full,
  output logic                     Drop
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [1:0]    buf_q [DEPTH];
  logic [1:0]    buf_d [DEPTH];
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] count_q, count_d;
  logic [1:0]    cur_dirn_q, cur_dirn_d;
  logic          step_q, step_d;
  logic          drop_q, drop_d;
  logic          empty_q, empty_d;
  logic          full_q, full_d;

  logic [1:0]    ref_dirn;
  logic          push_req, push_ok, pop;

  // Legality reference: newest queued entry, else the committed direction.
  // With Count==1 this is the entry being popped this cycle.
  always_comb begin
    ref_dirn = cur_dirn_q;
    if (count_q != CW'(0)) ref_dirn = buf_q[PW'(wr_q - PW'(1))];
  end

  // Push/pop qualification; a pop frees the slot a push into a full queue needs.
  always_comb begin
    pop      = Speed_Tick & q_Run & (count_q != CW'(0));
    push_req = SCEN & q_Run;
    push_ok  = push_req & (In_Dirn[1] != ref_dirn[1]) & (~full_q | pop);
  end

  // Next-state for queue storage, pointers, direction and status pulses.
  always_comb begin
    buf_d      = buf_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    count_d    = count_q;
    cur_dirn_d = cur_dirn_q;
    step_d     = 1'b0;
    drop_d     = 1'b0;

    if (q_Run) begin
      step_d = Speed_Tick;
      drop_d = push_req & ~push_ok;
      if (push_ok) begin
        buf_d[wr_q] = In_Dirn;
        wr_d        = PW'(wr_q + PW'(1));
      end
      if (pop) begin
        cur_dirn_d = buf_q[rd_q];
        rd_d       = PW'(rd_q + PW'(1));
      end
      count_d = CW'(count_q + CW'(push_ok) - CW'(pop));
    end else begin
      // Outside Run the queue is flushed continuously.
      rd_d    = '0;
      wr_d    = '0;
      count_d = '0;
      if (q_I) cur_dirn_d = INIT_DIRN;
    end

    empty_d = (count_d == CW'(0));
    full_d  = (count_d == CW'(DEPTH));
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      for (int i = 0; i < int'(DEPTH); i++) buf_q[i] <= 2'b00;
      rd_q       <= '0;
      wr_q       <= '0;
      count_q    <= '0;
      cur_dirn_q <= INIT_DIRN;
      step_q     <= 1'b0;
      drop_q     <= 1'b0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
    end else begin
      buf_q      <= buf_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      count_q    <= count_d;
      cur_dirn_q <= cur_dirn_d;
      step_q     <= step_d;
      drop_q     <= drop_d;
      empty_q    <= empty_d;
      full_q     <= full_d;
    end
  end

  assign Cur_Dirn = cur_dirn_q;
  assign Step     = step_q;
  assign Count    = count_q;
  assign Empty    = empty_q;
  assign Full     = full_q;
  assign Drop     = drop_q;

endmodule
